// File: rtl/count4_down_pkg.sv
// Shared constants for the count4_down down-counter slice.
package count4_down_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/dff_ar.sv
// 1-bit D flip-flop with asynchronous active-high clear to 0.
module dff_ar (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/count4_down.sv
// Free-running binary down counter with async active-high clear.
// Built as one dff_ar per bit plus a borrow-chain decrementer.
module count4_down
  import count4_down_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] nxt;

  // A borrow always enters bit 0, so the counter decrements every edge.
  assign b[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign nxt[i] = q[i] ^ b[i];

    if (i < WIDTH - 1) begin : g_borrow
      assign b[i+1] = b[i] & ~q[i];
    end

    dff_ar u_dff (
      .clk   (clk),
      .reset (reset),
      .d     (nxt[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_count4_down.sv
// Scoreboard bench for count4_down: stimulus queues expected q values,
// a monitor process pops and compares them.
module tb_count4_down;

  logic       clk;
  logic       reset;
  logic [3:0] q;

  logic [3:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         passed = 0;

  count4_down #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the DUT output against each queued expectation.
  initial begin
    logic [3:0] e;
    string      n;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (q === e) passed++;
      else $display("FAIL %s: q=%b expected %b", n, q, e);
    end
  end

  task automatic expect_q(input string n, input logic [3:0] v);
    exp_q.push_back(v);
    name_q.push_back(n);
    #0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int edges;
    reset = 1'b1;

    // Async clear before any clock edge.
    #2;
    expect_q("reset_no_edge", 4'd0);

    for (int i = 0; i < 3; i++) begin
      tick();
      expect_q("reset_hold", 4'd0);
    end

    // First counts after release, then full cycle and wrap.
    release_reset();
    tick(); expect_q("first_edge", 4'b1111);
    tick(); expect_q("second_edge", 4'b1110);
    tick(); expect_q("third_edge", 4'b1101);
    for (int n = 4; n <= 16; n++) begin
      tick();
      expect_q($sformatf("full_cycle_e%0d", n), 4'((16 - n) % 16));
    end
    tick(); expect_q("wrap_e17", 4'b1111);

    // Long run: 50 edges from release.
    @(negedge clk); reset = 1'b1;
    #1 expect_q("reset_midcycle_a", 4'd0);
    release_reset();
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (n == 50) expect_q("long_run_e50", 4'b1110);
    end

    // Mid-count reset at q = 0110, asserted between edges.
    @(negedge clk); reset = 1'b1;
    #1 expect_q("reset_clear_b", 4'd0);
    release_reset();
    edges = 10;
    for (int n = 1; n <= edges; n++) tick();
    expect_q("reach_0110", 4'b0110);
    #1 reset = 1'b1;
    #1 expect_q("midcount_reset", 4'd0);
    release_reset();
    tick(); expect_q("after_mid_reset", 4'b1111);

    // Reset coincident with a clock edge while q = 0011.
    for (int n = 1; n <= 12; n++) tick();
    expect_q("reach_0011", 4'b0011);
    @(posedge clk);
    reset = 1'b1;
    #1 expect_q("coincident_reset", 4'd0);
    tick(); expect_q("coincident_hold", 4'd0);
    release_reset();
    tick(); expect_q("coincident_resume", 4'b1111);

    // Drain with a bounded wait.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
